mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters: WIDTH default 16, data word width; INSTRUCTIONWIDTH default 24, instruction and storage word width; ADDRESSBITS default 8, implemented address bits; DEPTH = 2**ADDRESSBITS, number of storage words.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instrReq  input  1  instruction-fetch request; held high until granted.
REQ-005 instrAddress  input  WIDTH  fetch word address.
REQ-006 instrStall  output  1  combinational; fetch request not granted this cycle.
REQ-007 instrValid  output  1  registered; one-cycle pulse marking valid instruction.
REQ-008 instruction  output  INSTRUCTIONWIDTH  registered fetch data.
REQ-009 dataReq  input  1  data-port request; held high until granted.
REQ-010 dataWriteEnable  input  1  1 = write, 0 = read; qualified by dataReq.
REQ-011 dataAddress  input  WIDTH  data word address.
REQ-012 dataToWrite  input  WIDTH  write data.
REQ-013 dataStall  output  1  combinational; data request not granted this cycle.
REQ-014 dataValid  output  1  registered; one-cycle pulse after a granted read only.
REQ-015 dataOut  output  WIDTH  registered read data.
REQ-016 addrError  output  1  sticky out-of-range access flag.

Function
REQ-017 Storage SHALL be a single-port array of DEPTH x INSTRUCTIONWIDTH, with at most one access per cycle.
REQ-018 Arbitration SHALL grant the data port when dataReq=1, unless starveCount=3 and instrReq=1, in which case it SHALL grant the instruction port.
REQ-019 starveCount (2 bits) SHALL increment on each cycle in which instrReq=1 and data is granted, saturate at 3, and clear on any instruction grant or any cycle with instrReq=0.
REQ-020 instrStall SHALL equal instrReq AND NOT instruction-grant; dataStall SHALL equal dataReq AND NOT data-grant.
REQ-021 Granted reads SHALL have one-cycle latency: data is registered at the grant edge, and the valid pulse and data are visible in the following cycle.
REQ-022 Read data SHALL be the low WIDTH bits of the word; instruction SHALL be the full INSTRUCTIONWIDTH-bit word.
REQ-023 A granted write SHALL store {zeros, dataToWrite} at the grant edge, SHALL NOT pulse dataValid, and SHALL leave dataOut unchanged.
REQ-024 A read granted in the cycle after a write to the same address SHALL return the newly written value.
REQ-025 An address is in range when bits [WIDTH-1:ADDRESSBITS] are zero.
REQ-026 Out-of-range reads SHALL return zero and still pulse valid.
REQ-027 Out-of-range writes SHALL be discarded.
REQ-028 Any granted out-of-range access SHALL set addrError at that edge; addrError SHALL hold until reset.
REQ-029 instruction and dataOut SHALL hold their last value when no read of that port is granted.
REQ-030 Back-to-back grants to the same port SHALL produce valid in consecutive cycles, with no bubble.

Reset
REQ-031 While reset=1, instrValid, dataValid, instruction, dataOut, addrError and starveCount SHALL be 0, independent of clock.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 A grant in flight when reset asserts SHALL be dropped, with no valid pulse after reset release.
REQ-034 Stall outputs remain combinational during reset, and requests SHALL NOT be granted while reset=1.

Verification
REQ-035 Write 0x1234 to address 5, then read address 5 the next cycle -> dataValid=1 and dataOut=0x1234 one cycle after the read grant.
REQ-036 Preload word 0xABCDEF at address 3, then instrReq with instrAddress=3 and dataReq=0 -> instrStall=0, and next cycle instrValid=1, instruction=0xABCDEF.
REQ-037 instrReq and dataReq held high continuously -> grant pattern D,D,D,I repeating, instrStall high 3 of every 4 cycles, starveCount returning to 0 after each I.
REQ-038 Data write to address 0x0100 (ADDRESSBITS=8) -> storage unchanged, addrError=1 and still 1 after 10 idle cycles; a read of 0x0100 -> dataOut=0, dataValid=1.
REQ-039 Assert reset mid-cycle immediately after a read grant -> dataValid and addrError read 0 asynchronously, and no valid pulse after release.
REQ-040 Five consecutive data reads to addresses 0..4 -> dataValid high for five consecutive cycles, each carrying the matching word.

Source files
------------

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: single-port memory shared by an instruction-fetch port and a
// data read/write port. The data port has priority, but a waiting fetch is
// guaranteed a grant after three consecutive data grants. Each granted read
// returns its result one cycle later. Out-of-range accesses set a sticky
// error flag.
module mem_responder #(
    parameter int WIDTH            = 16,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int ADDRESSBITS      = 8
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic                        instrReq,
    input  logic [WIDTH-1:0]            instrAddress,
    output logic                        instrStall,
    output logic                        instrValid,
    output logic [INSTRUCTIONWIDTH-1:0] instruction,

    input  logic                        dataReq,
    input  logic                        dataWriteEnable,
    input  logic [WIDTH-1:0]            dataAddress,
    input  logic [WIDTH-1:0]            dataToWrite,
    output logic                        dataStall,
    output logic                        dataValid,
    output logic [WIDTH-1:0]            dataOut,

    output logic                        addrError
);

    localparam int DEPTH = 2 ** ADDRESSBITS;

    logic [INSTRUCTIONWIDTH-1:0] mem [DEPTH];

    logic [1:0]                  starveCount;
    logic [1:0]                  starveNext;
    logic                        grantData;
    logic                        grantInstr;
    logic [WIDTH-1:0]            accessAddress;
    logic                        inRange;
    logic [ADDRESSBITS-1:0]      memIndex;
    logic [INSTRUCTIONWIDTH-1:0] readWord;
    logic                        dataRead;
    logic                        dataWrite;

    // Arbitration: data wins unless the fetch port has been starved for three
    // cycles. Nothing is granted while reset is asserted.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grantData  = 1'b0;
        grantInstr = 1'b0;
        if (!reset) begin
            if (dataReq && !(starveCount == 2'd3 && instrReq)) begin
                grantData = 1'b1;
            end else if (instrReq) begin
                grantInstr = 1'b1;
            end
        end
    end

    assign instrStall = instrReq & ~grantInstr;
    assign dataStall  = dataReq & ~grantData;
    assign dataRead   = grantData & ~dataWriteEnable;
    assign dataWrite  = grantData & dataWriteEnable;

    // Single shared address path into storage, plus the range check.
    always_comb begin
        accessAddress = grantData ? dataAddress : instrAddress;
        inRange       = (accessAddress[WIDTH-1:ADDRESSBITS] == '0);
        memIndex      = accessAddress[ADDRESSBITS-1:0];
        readWord      = inRange ? mem[memIndex] : '0;
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_comb begin
        starveNext = starveCount;
        if (grantInstr || !instrReq) begin
            starveNext = 2'd0;
        end else if (grantData && starveCount != 2'd3) begin
            starveNext = starveCount + 2'd1;
        end
    end

    // Storage write port; out-of-range writes are discarded.
    // NOTE: the array has no reset, so it maps onto plain RAM; contents
    // survive reset, and writes are gated off during reset by the grant logic.
    always_ff @(posedge clock) begin
        if (dataWrite && inRange) begin
            mem[memIndex] <= INSTRUCTIONWIDTH'(dataToWrite);
        end
    end

    // Registered outputs: valid pulses, read data, sticky error, starvation state.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            instrValid  <= 1'b0;
            dataValid   <= 1'b0;
            instruction <= '0;
            dataOut     <= '0;
            addrError   <= 1'b0;
            starveCount <= 2'd0;
        end else begin
            instrValid  <= grantInstr;
            dataValid   <= dataRead;
            starveCount <= starveNext;
            if (grantInstr) begin
                instruction <= readWord;
            end
            if (dataRead) begin
                dataOut <= readWord[WIDTH-1:0];
            end
            if ((grantData || grantInstr) && !inRange) begin
                addrError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Directed testbench for mem_responder: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_mem_responder;

    logic        clock;
    logic        reset;
    logic        instrReq;
    logic [15:0] instrAddress;
    logic        instrStall;
    logic        instrValid;
    logic [23:0] instruction;
    logic        dataReq;
    logic        dataWriteEnable;
    logic [15:0] dataAddress;
    logic [15:0] dataToWrite;
    logic        dataStall;
    logic        dataValid;
    logic [15:0] dataOut;
    logic        addrError;

    int checkCount = 0;
    int passCount  = 0;

    mem_responder #(
        .WIDTH            (16),
        .INSTRUCTIONWIDTH (24),
        .ADDRESSBITS      (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .instrReq        (instrReq),
        .instrAddress    (instrAddress),
        .instrStall      (instrStall),
        .instrValid      (instrValid),
        .instruction     (instruction),
        .dataReq         (dataReq),
        .dataWriteEnable (dataWriteEnable),
        .dataAddress     (dataAddress),
        .dataToWrite     (dataToWrite),
        .dataStall       (dataStall),
        .dataValid       (dataValid),
        .dataOut         (dataOut),
        .addrError       (addrError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        reset           = 1'b1;
        instrReq        = 1'b0;
        instrAddress    = 16'h0000;
        dataReq         = 1'b1;
        dataWriteEnable = 1'b0;
        dataAddress     = 16'h0000;
        dataToWrite     = 16'h0000;
        #1;
        checkCount++;
        if ({instrValid, dataValid, addrError} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {instrValid, dataValid, addrError});
        else passCount++;
        checkCount++;
        if ({instruction, dataOut} !== 40'h0) $display("FAIL reset_data: got %h want 0", {instruction, dataOut});
        else passCount++;
        checkCount++;
        if (dut.starveCount !== 2'd0) $display("FAIL reset_starve: got %0d want 0", dut.starveCount);
        else passCount++;
        // Requests are not granted under reset, so the stall shows combinationally.
        checkCount++;
        if (dataStall !== 1'b1) $display("FAIL reset_dstall: got %b want 1", dataStall);
        else passCount++;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b0) $display("FAIL reset_noclk_valid: got %b want 0", dataValid);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_write_read;
        @(negedge clock);
        dataReq = 1'b1; dataWriteEnable = 1'b1; dataAddress = 16'h0005; dataToWrite = 16'h1234;
        #1;
        checkCount++;
        if (dataStall !== 1'b0) $display("FAIL wr_stall: got %b want 0", dataStall);
        else passCount++;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b0) $display("FAIL wr_novalid: got %b want 0", dataValid);
        else passCount++;
        @(negedge clock);
        dataWriteEnable = 1'b0;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b1 || dataOut !== 16'h1234) $display("FAIL rd_after_wr: got valid=%b data=%h want 1/1234", dataValid, dataOut);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b0 || dataOut !== 16'h1234) $display("FAIL rd_hold: got valid=%b data=%h want 0/1234", dataValid, dataOut);
        else passCount++;
    endtask

    task automatic test_instr_fetch;
        @(negedge clock);
        dut.mem[3] = 24'hABCDEF;
        instrReq = 1'b1; instrAddress = 16'h0003;
        #1;
        checkCount++;
        if (instrStall !== 1'b0) $display("FAIL if_stall: got %b want 0", instrStall);
        else passCount++;
        @(posedge clock); #1;
        checkCount++;
        if (instrValid !== 1'b1 || instruction !== 24'hABCDEF) $display("FAIL if_data: got valid=%b instr=%h want 1/abcdef", instrValid, instruction);
        else passCount++;
        @(negedge clock);
        instrReq = 1'b0;
        dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 16'h0003;
        @(posedge clock); #1;
        checkCount++;
        if (instrValid !== 1'b0 || instruction !== 24'hABCDEF) $display("FAIL if_hold: got valid=%b instr=%h want 0/abcdef", instrValid, instruction);
        else passCount++;
        // The data port sees only the low 16 bits of the stored word.
        checkCount++;
        if (dataValid !== 1'b1 || dataOut !== 16'hCDEF) $display("FAIL rd_low_bits: got valid=%b data=%h want 1/cdef", dataValid, dataOut);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
    endtask

    task automatic test_arbitration;
        @(negedge clock);
        instrReq = 1'b1; instrAddress = 16'h0003;
        dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 16'h0005;
        for (int i = 0; i < 8; i++) begin
            logic       expI;
            logic [1:0] expStarve;
            expI      = (i % 4 == 3);
            expStarve = expI ? 2'd0 : 2'((i % 4) + 1);
            #1;
            checkCount++;
            if (instrStall !== ~expI || dataStall !== expI) $display("FAIL arb_stall[%0d]: got is=%b ds=%b want is=%b ds=%b", i, instrStall, dataStall, ~expI, expI);
            else passCount++;
            @(posedge clock); #1;
            checkCount++;
            if (instrValid !== expI || dataValid !== ~expI) $display("FAIL arb_valid[%0d]: got iv=%b dv=%b want iv=%b dv=%b", i, instrValid, dataValid, expI, ~expI);
            else passCount++;
            checkCount++;
            if (dut.starveCount !== expStarve) $display("FAIL arb_starve[%0d]: got %0d want %0d", i, dut.starveCount, expStarve);
            else passCount++;
            @(negedge clock);
        end
        checkCount++;
        if (dataOut !== 16'h1234 || instruction !== 24'hABCDEF) $display("FAIL arb_data: got data=%h instr=%h want 1234/abcdef", dataOut, instruction);
        else passCount++;
        instrReq = 1'b0; dataReq = 1'b0;
        @(posedge clock); #1;
        checkCount++;
        if (dut.starveCount !== 2'd0) $display("FAIL arb_starve_idle: got %0d want 0", dut.starveCount);
        else passCount++;
    endtask

    task automatic test_out_of_range;
        @(negedge clock);
        dataReq = 1'b1; dataWriteEnable = 1'b1; dataAddress = 16'h0000; dataToWrite = 16'h5555;
        @(posedge clock); #1;
        checkCount++;
        if (addrError !== 1'b0) $display("FAIL oor_inrange_err: got %b want 0", addrError);
        else passCount++;
        @(negedge clock);
        dataAddress = 16'h0100; dataToWrite = 16'hBEEF;
        @(posedge clock); #1;
        checkCount++;
        if (addrError !== 1'b1 || dataValid !== 1'b0) $display("FAIL oor_wr: got err=%b valid=%b want 1/0", addrError, dataValid);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0; dataWriteEnable = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checkCount++;
        if (addrError !== 1'b1) $display("FAIL oor_sticky: got %b want 1", addrError);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b1; dataAddress = 16'h0000;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b1 || dataOut !== 16'h5555) $display("FAIL oor_discard: got valid=%b data=%h want 1/5555", dataValid, dataOut);
        else passCount++;
        @(negedge clock);
        dataAddress = 16'h0100;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b1 || dataOut !== 16'h0000) $display("FAIL oor_rd: got valid=%b data=%h want 1/0000", dataValid, dataOut);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5A5A};
        @(negedge clock);
        dataReq = 1'b1; dataWriteEnable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dataAddress = 16'(i); dataToWrite = words[i];
            @(negedge clock);
        end
        dataWriteEnable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dataAddress = 16'(i);
            @(posedge clock); #1;
            checkCount++;
            if (dataValid !== 1'b1 || dataOut !== words[i]) $display("FAIL b2b_rd[%0d]: got valid=%b data=%h want 1/%h", i, dataValid, dataOut, words[i]);
            else passCount++;
            @(negedge clock);
        end
        dataReq = 1'b0;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b0) $display("FAIL b2b_end: got %b want 0", dataValid);
        else passCount++;
    endtask

    task automatic test_reset_in_flight;
        @(negedge clock);
        dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 16'h0100;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checkCount++;
        if (dataValid !== 1'b0 || addrError !== 1'b0 || dataOut !== 16'h0000) $display("FAIL rif_async: got valid=%b err=%b data=%h want 0/0/0000", dataValid, addrError, dataOut);
        else passCount++;
        checkCount++;
        if (dataStall !== 1'b1) $display("FAIL rif_stall: got %b want 1", dataStall);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
        reset   = 1'b0;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b0 || instrValid !== 1'b0) $display("FAIL rif_no_pulse: got dv=%b iv=%b want 0/0", dataValid, instrValid);
        else passCount++;
        // Storage keeps its contents across reset.
        @(negedge clock);
        dataReq = 1'b1; dataAddress = 16'h0001;
        @(posedge clock); #1;
        checkCount++;
        if (dataValid !== 1'b1 || dataOut !== 16'h2222) $display("FAIL rif_mem_kept: got valid=%b data=%h want 1/2222", dataValid, dataOut);
        else passCount++;
        @(negedge clock);
        dataReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_instr_fetch();
        test_arbitration();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
